issp_access_arbiter: RTL and testbench
======================================

# issp_access_arbiter

Shares one in-system source/probe instance (altsource_probe-style: a `source` vector driven into the design and a `probe` vector sampled from it) among several on-chip requesters. The block grants requesters round-robin, drives the shared source register on writes, synchronizes and captures the probe vector on reads, and enforces a settle window per access. It sits between the NLB debug/status clients and the source/probe instance in the emulator build.

## Interface
- NUM_REQ, 4: number of requesters; valid range 2..8.
- SOURCE_WIDTH, 32: width of the shared source vector.
- PROBE_WIDTH, 32: width of the shared probe vector.
- SOURCE_INIT, 0: value loaded into `source` at reset.
- SETTLE_CYCLES, 2: cycles held in SETTLE per access; must be ≥1.

Ports:
- source_clk  in  1  sole clock; all logic rises on it.
- clr_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when 0, no new grant is issued; an access in flight still completes.
- req  in  NUM_REQ  per-requester access request; level, held until `done` with matching `gnt`.
- req_wr  in  NUM_REQ  per-requester op: 1 = source write, 0 = probe read.
- req_wdata  in  NUM_REQ*SOURCE_WIDTH  per-requester write data; slice i at [i*SOURCE_WIDTH +: SOURCE_WIDTH].
- gnt  out  NUM_REQ  one-hot grant, high for the whole access.
- done  out  1  one-cycle completion pulse for the granted requester.
- rdata  out  PROBE_WIDTH  probe value captured by the most recent read; holds until the next read.
- busy  out  1  high whenever state ≠ IDLE.
- source  out  SOURCE_WIDTH  registered source vector to the source/probe instance.
- probe  in  PROBE_WIDTH  asynchronous probe vector from the source/probe instance.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE: when ena=1 and any req bit set, the winner is the first set bit at or after rr_ptr, scanning upward with wrap at NUM_REQ-1→0. On the clock edge: gnt ← one-hot(winner), op latched from req_wr[winner], settle counter ← 0, and on a write source ← req_wdata slice of the winner. Next state SETTLE.
- SETTLE: counter increments each cycle. When counter = SETTLE_CYCLES-1, the next state is DONE.
- DONE: done=1 for exactly this cycle; gnt is still asserted. On a read, rdata was loaded from probe_sync on the edge entering DONE. rr_ptr ← (winner+1) mod NUM_REQ. The next edge returns to IDLE and clears gnt.
- Probe synchronizer: a free-running 2-flop synchronizer, probe → probe_sync, independent of state. Reads capture only probe_sync, never the raw probe.
- A write does not modify rdata; a read does not modify source.
- After grant, req, req_wr, and req_wdata changes are ignored; the access completes unconditionally, including if req drops.
- Requests from non-granted requesters wait; there is no queueing beyond the req level.
- Counter width is $clog2(SETTLE_CYCLES+1); it never wraps because it is reset on each grant.

## Timing
- Reset values (asynchronous on clr_n=0): state=IDLE, gnt=0, done=0, busy=0, rdata=0, source=SOURCE_INIT, rr_ptr=0, counter=0, probe_sync=0.
- clr_n asserted mid-access aborts immediately. source returns to SOURCE_INIT, and no done pulse is produced. Deassertion is synchronized externally; the first grant is possible on the first edge after release.
- Latency: req sampled in IDLE at cycle 0 gives gnt high and source updated from cycle 1, and done at cycle 1+SETTLE_CYCLES. The access occupies 2+SETTLE_CYCLES cycles from sampling to the next IDLE, so the next grant is sampled at cycle 2+SETTLE_CYCLES.
- Probe-to-rdata: a probe change must be stable ≥2 cycles before the DONE-entry edge to be captured.
- A back-to-back requester that keeps req high is re-granted only if no other requester is pending, which follows from rr_ptr advancing past it.
- ena dropping during SETTLE or DONE has no effect on the current access.

## Test plan
- Reset: hold clr_n=0 with SOURCE_INIT=0xA5A5_0000. Required: source=0xA5A5_0000, and gnt, done, busy, and rdata all 0. Release, with no req: busy stays 0.
- Single write, SETTLE_CYCLES=2: req[1]=1, req_wr[1]=1, data 0x1234_5678 at cycle 0. Required: gnt=0010 and source=0x1234_5678 at cycle 1; done at cycle 3; gnt=0 at cycle 4.
- Single read: hold probe=0xDEAD_BEEF, then req[2] read. Required: rdata=0xDEAD_BEEF coincident with done, and source unchanged.
- Round-robin fairness: req=1111 held continuously, all reads. Required: grant order 0,1,2,3,0, each access 4 cycles apart.
- ena gating: ena=0 with req[0]=1. Required: no gnt. Then drop ena mid-access: the current access still completes with done.
- Mid-access reset: assert clr_n during SETTLE of a write of 0xFFFF_FFFF. Required: source returns to SOURCE_INIT, gnt=0, and no done pulse.

Source files
------------

// File: rtl/issp_access_arbiter.sv
// Round-robin arbiter sharing one source/probe instance among NUM_REQ requesters.
// Writes drive the shared source register; reads capture the synchronized probe vector.
module issp_access_arbiter #(
    parameter int                      NUM_REQ       = 4,
    parameter int                      SOURCE_WIDTH  = 32,
    parameter int                      PROBE_WIDTH   = 32,
    parameter logic [SOURCE_WIDTH-1:0] SOURCE_INIT   = '0,
    parameter int                      SETTLE_CYCLES = 2
) (
    input  logic                            source_clk,
    input  logic                            clr_n,
    input  logic                            ena,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*SOURCE_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            done,
    output logic [PROBE_WIDTH-1:0]          rdata,
    output logic                            busy,
    output logic [SOURCE_WIDTH-1:0]         source,
    input  logic [PROBE_WIDTH-1:0]          probe
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [NUM_REQ-1:0]        r_gnt;
    logic                      r_done;
    logic                      r_busy;
    logic                      r_op;
    logic [IDX_W-1:0]          r_winner;
    logic [IDX_W-1:0]          r_rr_ptr;
    logic [PROBE_WIDTH-1:0]    r_rdata;
    logic [SOURCE_WIDTH-1:0]   r_source;
    logic [PROBE_WIDTH-1:0]    r_probe_meta;
    logic [PROBE_WIDTH-1:0]    r_probe_sync;

    logic                      w_found;
    logic [IDX_W-1:0]          w_winner;
    logic [NUM_REQ-1:0]        w_onehot;
    logic [SOURCE_WIDTH-1:0]   w_wdata;
    logic [IDX_W-1:0]          w_rr_next;

    // Round-robin scan: first set request at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin : winner_scan
        int k;
        k        = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(r_rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end else begin
                k = k;
            end
            if (!w_found && req[IDX_W'(k)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(k);
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Grant vector, write data and pointer advance derived from the scan and latched winner.
    always_comb begin
        w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
        w_wdata   = req_wdata[int'(w_winner)*SOURCE_WIDTH +: SOURCE_WIDTH];
        if (r_winner == IDX_LAST) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = r_winner + 1'b1;
        end
    end

    // Free-running two-flop synchronizer for the asynchronous probe vector.
    always_ff @(posedge source_clk or negedge clr_n) begin
        if (!clr_n) begin
            r_probe_meta <= '0;
            r_probe_sync <= '0;
        end else begin
            r_probe_meta <= probe;
            r_probe_sync <= r_probe_meta;
        end
    end

    // Access FSM: grant in IDLE, hold for SETTLE_CYCLES, pulse done, then release.
    always_ff @(posedge source_clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_op     <= 1'b0;
            r_winner <= '0;
            r_rr_ptr <= '0;
            r_rdata  <= '0;
            r_source <= SOURCE_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ena && w_found) begin
                        r_state  <= ST_SETTLE;
                        r_gnt    <= w_onehot;
                        r_winner <= w_winner;
                        r_op     <= req_wr[w_winner];
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (req_wr[w_winner]) begin
                            r_source <= w_wdata;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Counter is wide enough to hold SETTLE_CYCLES, so this never wraps.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        if (!r_op) begin
                            r_rdata <= r_probe_sync;
                        end
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_done   <= 1'b0;
                    r_gnt    <= '0;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_rr_next;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = r_busy;
    assign rdata  = r_rdata;
    assign source = r_source;

endmodule

// File: tb/tb_issp_access_arbiter.sv
// Directed, table-driven bench for issp_access_arbiter (4 requesters, 32-bit, settle of 2).
module tb_issp_access_arbiter;

    localparam int          NREQ  = 4;
    localparam int          SW    = 32;
    localparam int          PW    = 32;
    localparam logic [31:0] SINIT = 32'hA5A5_0000;

    logic                 clk;
    logic                 clr_n;
    logic                 ena;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*SW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic                 done;
    logic [PW-1:0]        rdata;
    logic                 busy;
    logic [SW-1:0]        source;
    logic [PW-1:0]        probe;

    int checks = 0;
    int errors = 0;

    issp_access_arbiter #(
        .NUM_REQ(NREQ), .SOURCE_WIDTH(SW), .PROBE_WIDTH(PW),
        .SOURCE_INIT(SINIT), .SETTLE_CYCLES(2)
    ) dut (
        .source_clk(clk), .clr_n(clr_n), .ena(ena), .req(req), .req_wr(req_wr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .source(source), .probe(probe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] wbase;      // slice i carries wbase + i
        logic [31:0] probe;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_source;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wdata(input logic [31:0] base);
        for (int i = 0; i < NREQ; i++) req_wdata[i*SW +: SW] = base + 32'(i);
    endtask

    initial begin
        vecs[0] = '{4'b0010, 4'b0010, 32'h1234_5677, 32'h0000_0000, 4'b0010, 32'h1234_5678, 32'h0000_0000};
        vecs[1] = '{4'b0100, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 4'b0100, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[2] = '{4'b0001, 4'b0001, 32'hCAFE_F00D, 32'h1111_1111, 4'b0001, 32'hCAFE_F00D, 32'hDEAD_BEEF};
        vecs[3] = '{4'b1000, 4'b0000, 32'h0000_0000, 32'h0BAD_F00D, 4'b1000, 32'hCAFE_F00D, 32'h0BAD_F00D};
        vecs[4] = '{4'b0101, 4'b0000, 32'h0000_0000, 32'h55AA_55AA, 4'b0001, 32'hCAFE_F00D, 32'h55AA_55AA};
        vecs[5] = '{4'b0101, 4'b0101, 32'h1000_0000, 32'h7777_7777, 4'b0100, 32'h1000_0002, 32'h55AA_55AA};

        clr_n = 1'b0; ena = 1'b1; req = '0; req_wr = '0; req_wdata = '0; probe = '0;

        // Reset state
        #12;
        chk("rst_source", source, SINIT);
        chk("rst_gnt",    32'(gnt), 32'h0);
        chk("rst_done",   32'(done), 32'h0);
        chk("rst_busy",   32'(busy), 32'h0);
        chk("rst_rdata",  rdata, 32'h0);
        tick();
        clr_n = 1'b1;
        tick(); tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // Table-driven single accesses
        for (int v = 0; v < 6; v++) begin
            probe = vecs[v].probe;
            tick(); tick(); tick();
            req = vecs[v].req; req_wr = vecs[v].wr; set_wdata(vecs[v].wbase);
            tick();                                   // cycle 1
            chk($sformatf("v%0d_gnt_c1", v), 32'(gnt), 32'(vecs[v].exp_gnt));
            chk($sformatf("v%0d_src_c1", v), source, vecs[v].exp_source);
            tick();                                   // cycle 2
            chk($sformatf("v%0d_done_c2", v), 32'(done), 32'h0);
            tick();                                   // cycle 3
            chk($sformatf("v%0d_done_c3", v), 32'(done), 32'h1);
            chk($sformatf("v%0d_gnt_c3", v), 32'(gnt), 32'(vecs[v].exp_gnt));
            chk($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
            chk($sformatf("v%0d_src_c3", v), source, vecs[v].exp_source);
            req = '0; req_wr = '0;
            tick();                                   // cycle 4
            chk($sformatf("v%0d_gnt_c4", v), 32'(gnt), 32'h0);
            chk($sformatf("v%0d_busy_c4", v), 32'(busy), 32'h0);
        end

        // Round-robin fairness from a fresh pointer
        clr_n = 1'b0; #2; clr_n = 1'b1;
        req = 4'b1111; req_wr = 4'b0000;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c % 4 == 1) chk($sformatf("rr_gnt_c%0d", c), 32'(gnt), 32'(4'b0001 << (((c-1)/4) % 4)));
            if (c % 4 == 3) chk($sformatf("rr_done_c%0d", c), 32'(done), 32'h1);
            if (c % 4 == 0) chk($sformatf("rr_idle_c%0d", c), 32'(gnt), 32'h0);
        end
        req = '0;
        tick(); tick(); tick();
        chk("rr_end_busy", 32'(busy), 32'h0);

        // ena gating, then ena dropped mid-access
        ena = 1'b0; req = 4'b0001;
        tick(); tick(); tick();
        chk("ena0_gnt",  32'(gnt), 32'h0);
        chk("ena0_busy", 32'(busy), 32'h0);
        ena = 1'b1;
        tick();
        chk("ena1_gnt", 32'(gnt), 32'h1);
        ena = 1'b0;
        tick(); tick();
        chk("ena_drop_done", 32'(done), 32'h1);
        req = '0;
        tick();
        chk("ena_drop_gnt", 32'(gnt), 32'h0);
        ena = 1'b1;

        // Reset during SETTLE of a write
        req = 4'b1000; req_wr = 4'b1000; set_wdata(32'hFFFF_FFFC);
        tick();
        chk("mid_src_wr", source, 32'hFFFF_FFFF);
        tick();
        clr_n = 1'b0; #1;
        chk("mid_src_init", source, SINIT);
        chk("mid_gnt",      32'(gnt), 32'h0);
        chk("mid_busy",     32'(busy), 32'h0);
        req = '0; req_wr = '0;
        tick();
        clr_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("mid_nodone_%0d", c), 32'(done), 32'h0);
        end
        chk("mid_src_final", source, SINIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
